mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the multicycle core's instruction

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (IF)
// and the load/store unit (D). It sequences each command and returns read data after MEM_LAT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    logic [1:0]        state_reg;
    logic [2:0]        wait_cnt_reg;
    logic              owner_reg;
    logic              last_owner_reg;
    logic              store_reg;
    logic              if_gnt_reg;
    logic              if_rvalid_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic              d_gnt_reg;
    logic              d_rvalid_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              mem_en_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              busy_reg;

    logic any_req;
    logic pick_d;

    // On a tie, the port that did not own the previous command wins.
    assign any_req = if_req | d_req;
    assign pick_d  = d_req & (~if_req | (last_owner_reg == OWN_IF));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            wait_cnt_reg   <= '0;
            owner_reg      <= OWN_IF;
            last_owner_reg <= OWN_D;
            store_reg      <= 1'b0;
            if_gnt_reg     <= 1'b0;
            if_rvalid_reg  <= 1'b0;
            if_rdata_reg   <= '0;
            d_gnt_reg      <= 1'b0;
            d_rvalid_reg   <= 1'b0;
            d_rdata_reg    <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            busy_reg       <= 1'b0;
        end else begin
            if_gnt_reg    <= 1'b0;
            d_gnt_reg     <= 1'b0;
            if_rvalid_reg <= 1'b0;
            d_rvalid_reg  <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        // The registered memory command doubles as the winner's latch.
                        owner_reg      <= pick_d;
                        last_owner_reg <= pick_d;
                        store_reg      <= pick_d & d_we;
                        mem_en_reg     <= 1'b1;
                        mem_we_reg     <= pick_d & d_we;
                        mem_addr_reg   <= pick_d ? d_addr : if_addr;
                        mem_wdata_reg  <= pick_d ? d_wdata : '0;
                        if_gnt_reg     <= ~pick_d;
                        d_gnt_reg      <= pick_d;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (store_reg) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        wait_cnt_reg <= LAT;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    if (wait_cnt_reg == 3'd1) begin
                        if (owner_reg == OWN_D) begin
                            d_rdata_reg  <= mem_rdata;
                            d_rvalid_reg <= 1'b1;
                        end else begin
                            if_rdata_reg  <= mem_rdata;
                            if_rvalid_reg <= 1'b1;
                        end
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_reg;
    assign if_rvalid = if_rvalid_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_gnt     = d_gnt_reg;
    assign d_rvalid  = d_rvalid_reg;
    assign d_rdata   = d_rdata_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each backed by a latency-accurate memory model that returns junk outside the valid cycle.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // MEM_LAT = 1 instance
    logic        l1_if_req, l1_if_gnt, l1_if_rvalid;
    logic [31:0] l1_if_addr, l1_if_rdata;
    logic        l1_d_req, l1_d_we, l1_d_gnt, l1_d_rvalid;
    logic [31:0] l1_d_addr, l1_d_wdata, l1_d_rdata;
    logic        l1_mem_en, l1_mem_we, l1_busy;
    logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

    // MEM_LAT = 3 instance
    logic        l3_if_req, l3_if_gnt, l3_if_rvalid;
    logic [31:0] l3_if_addr, l3_if_rdata;
    logic        l3_d_req, l3_d_we, l3_d_gnt, l3_d_rvalid;
    logic [31:0] l3_d_addr, l3_d_wdata, l3_d_rdata;
    logic        l3_mem_en, l3_mem_we, l3_busy;
    logic [31:0] l3_mem_addr, l3_mem_wdata, l3_mem_rdata;

    logic [134:0] l1_outs, l3_outs;
    assign l1_outs = {l1_if_gnt, l1_if_rvalid, l1_if_rdata, l1_d_gnt, l1_d_rvalid, l1_d_rdata,
                      l1_mem_en, l1_mem_we, l1_mem_addr, l1_mem_wdata, l1_busy};
    assign l3_outs = {l3_if_gnt, l3_if_rvalid, l3_if_rdata, l3_d_gnt, l3_d_rvalid, l3_d_rdata,
                      l3_mem_en, l3_mem_we, l3_mem_addr, l3_mem_wdata, l3_busy};

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt),
        .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_gnt(l1_d_gnt), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_l3 (
        .clk(clk), .rst(rst),
        .if_req(l3_if_req), .if_addr(l3_if_addr), .if_gnt(l3_if_gnt),
        .if_rvalid(l3_if_rvalid), .if_rdata(l3_if_rdata),
        .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
        .d_gnt(l3_d_gnt), .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata),
        .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
        .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata), .busy(l3_busy)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0040_0000)      return 32'h0050_0093;
        else if (a == 32'h1001_0004) return 32'h1234_5678;
        else                         return a ^ 32'hA5A5_A5A5;
    endfunction

    // Memory models: data is valid only MEM_LAT cycles after the mem_en cycle.
    logic        p1_v = 1'b0;
    logic [31:0] p1_a = '0;
    always_ff @(posedge clk) begin
        p1_v <= l1_mem_en & ~l1_mem_we;
        p1_a <= l1_mem_addr;
    end
    assign l1_mem_rdata = p1_v ? mem_data(p1_a) : 32'hBAD0_BAD0;

    logic [2:0]  p3_v = '0;
    logic [31:0] p3_a [0:2];
    always_ff @(posedge clk) begin
        p3_v  <= {p3_v[1:0], l3_mem_en & ~l3_mem_we};
        p3_a[0] <= l3_mem_addr;
        p3_a[1] <= p3_a[0];
        p3_a[2] <= p3_a[1];
    end
    assign l3_mem_rdata = p3_v[2] ? mem_data(p3_a[2]) : 32'hBAD0_BAD0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        l1_if_req = 0; l1_if_addr = '0; l1_d_req = 0; l1_d_we = 0; l1_d_addr = '0; l1_d_wdata = '0;
        l3_if_req = 0; l3_if_addr = '0; l3_d_req = 0; l3_d_we = 0; l3_d_addr = '0; l3_d_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        tick();
        tick();
        rst = 1;
        tick();
    endtask

    // Ticks until a grant appears on the given instance; timeout counts as a failed check.
    task automatic wait_gnt(input bit on_l3, output logic gi, output logic gd, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
            gi = on_l3 ? l3_if_gnt : l1_if_gnt;
            gd = on_l3 ? l3_d_gnt : l1_d_gnt;
        end while (!(gi || gd) && cyc < 20);
        checks++;
        if (!(gi || gd)) begin
            errors++;
            $display("FAIL gnt_timeout: no grant after %0d cycles (required a grant)", cyc);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        tick();
        tick();
        checks++;
        if (l1_outs !== '0) begin
            errors++;
            $display("FAIL reset_outs_l1: got %h required 0", l1_outs);
        end
        checks++;
        if (l3_outs !== '0) begin
            errors++;
            $display("FAIL reset_outs_l3: got %h required 0", l3_outs);
        end
        rst = 1;
        tick();
        checks++;
        if ({l1_busy, l3_busy, l1_mem_en, l3_mem_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: busy/mem_en got %b required 0000",
                     {l1_busy, l3_busy, l1_mem_en, l3_mem_en});
        end
        $display("reset: outputs cleared, idle after release");
    endtask

    task automatic test_fetch();
        l1_if_addr = 32'h0040_0000;
        l1_if_req  = 1;
        tick();
        checks++;
        if ({l1_if_gnt, l1_mem_en, l1_mem_we, l1_mem_addr} !== {3'b110, 32'h0040_0000}) begin
            errors++;
            $display("FAIL fetch_cmd: gnt/en/we/addr got %b%b%b %h required 110 00400000",
                     l1_if_gnt, l1_mem_en, l1_mem_we, l1_mem_addr);
        end
        l1_if_req = 0;
        tick();
        checks++;
        if ({l1_if_gnt, l1_if_rvalid, l1_mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_wait: gnt/rvalid/en got %b required 000",
                     {l1_if_gnt, l1_if_rvalid, l1_mem_en});
        end
        tick();
        checks++;
        if ({l1_if_rvalid, l1_if_rdata} !== {1'b1, 32'h0050_0093}) begin
            errors++;
            $display("FAIL fetch_resp: rvalid/rdata got %b %h required 1 00500093",
                     l1_if_rvalid, l1_if_rdata);
        end
        tick();
        checks++;
        if ({l1_if_rvalid, l1_busy} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_done: rvalid/busy got %b required 00", {l1_if_rvalid, l1_busy});
        end
        $display("fetch: addr=%h rdata=%h", 32'h0040_0000, l1_if_rdata);
    endtask

    task automatic test_round_robin();
        logic gi, gd;
        int   cyc;
        logic exp_if;
        do_reset();
        l1_if_addr = 32'h0040_0010;
        l1_d_addr  = 32'h1001_0020;
        l1_d_we    = 0;
        l1_if_req  = 1;
        l1_d_req   = 1;
        for (int n = 0; n < 4; n++) begin
            wait_gnt(1'b0, gi, gd, cyc);
            exp_if = (n % 2 == 0);
            checks++;
            if ({gi, gd} !== {exp_if, ~exp_if}) begin
                errors++;
                $display("FAIL rr_order[%0d]: if_gnt/d_gnt got %b%b required %b%b",
                         n, gi, gd, exp_if, ~exp_if);
            end
            checks++;
            if (l1_mem_addr !== (exp_if ? l1_if_addr : l1_d_addr)) begin
                errors++;
                $display("FAIL rr_addr[%0d]: mem_addr got %h required %h",
                         n, l1_mem_addr, exp_if ? l1_if_addr : l1_d_addr);
            end
            $display("rr grant %0d: owner=%s mem_addr=%h", n, gi ? "IF" : "D", l1_mem_addr);
        end
        l1_if_req = 0;
        l1_d_req  = 0;
        repeat (5) tick();
    endtask

    task automatic test_store();
        logic gi, gd;
        int   cyc;
        logic seen_rvalid;
        l1_d_we    = 1;
        l1_d_addr  = 32'h1001_0000;
        l1_d_wdata = 32'hDEAD_BEEF;
        l1_d_req   = 1;
        wait_gnt(1'b0, gi, gd, cyc);
        checks++;
        if ({gd, gi, cyc == 1} !== 3'b101) begin
            errors++;
            $display("FAIL store_gnt: d_gnt/if_gnt got %b%b after %0d cycles required 10 after 1",
                     gd, gi, cyc);
        end
        checks++;
        if ({l1_mem_en, l1_mem_we, l1_mem_addr, l1_mem_wdata, l1_busy} !==
            {2'b11, 32'h1001_0000, 32'hDEAD_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL store_cmd: en/we/addr/wdata/busy got %b%b %h %h %b required 11 10010000 deadbeef 1",
                     l1_mem_en, l1_mem_we, l1_mem_addr, l1_mem_wdata, l1_busy);
        end
        seen_rvalid = l1_d_rvalid;
        l1_d_req = 0;
        l1_d_we  = 0;
        tick();
        checks++;
        if ({l1_busy, l1_mem_en, l1_mem_we, l1_d_gnt} !== 4'b0000) begin
            errors++;
            $display("FAIL store_done: busy/en/we/gnt got %b required 0000",
                     {l1_busy, l1_mem_en, l1_mem_we, l1_d_gnt});
        end
        for (int i = 0; i < 5; i++) begin
            seen_rvalid = seen_rvalid | l1_d_rvalid;
            tick();
        end
        checks++;
        if (seen_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL store_no_rvalid: d_rvalid seen=%b required 0", seen_rvalid);
        end
        $display("store: addr=%h wdata=%h", 32'h1001_0000, 32'hDEAD_BEEF);
    endtask

    task automatic test_load_lat3();
        logic gi, gd;
        int   cyc;
        logic early;
        l3_if_addr = 32'h0040_0000;
        l3_if_req  = 1;
        wait_gnt(1'b1, gi, gd, cyc);
        l3_if_req = 0;
        repeat (4) tick();
        checks++;
        if ({l3_if_rvalid, l3_if_rdata} !== {1'b1, 32'h0050_0093}) begin
            errors++;
            $display("FAIL lat3_fetch: rvalid/rdata got %b %h required 1 00500093",
                     l3_if_rvalid, l3_if_rdata);
        end
        repeat (2) tick();
        l3_d_addr = 32'h1001_0004;
        l3_d_we   = 0;
        l3_d_req  = 1;
        wait_gnt(1'b1, gi, gd, cyc);
        checks++;
        if ({gd, l3_mem_addr} !== {1'b1, 32'h1001_0004}) begin
            errors++;
            $display("FAIL lat3_gnt: d_gnt/mem_addr got %b %h required 1 10010004", gd, l3_mem_addr);
        end
        l3_d_req = 0;
        early = 0;
        for (int i = 1; i < 4; i++) begin
            tick();
            early = early | l3_d_rvalid;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL lat3_early: d_rvalid before 4 cycles got %b required 0", early);
        end
        tick();
        checks++;
        if ({l3_d_rvalid, l3_d_rdata} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL lat3_load: d_rvalid/d_rdata got %b %h required 1 12345678",
                     l3_d_rvalid, l3_d_rdata);
        end
        checks++;
        if ({l3_if_rvalid, l3_if_rdata} !== {1'b0, 32'h0050_0093}) begin
            errors++;
            $display("FAIL lat3_if_untouched: if_rvalid/if_rdata got %b %h required 0 00500093",
                     l3_if_rvalid, l3_if_rdata);
        end
        tick();
        checks++;
        if (l3_d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL lat3_pulse: d_rvalid got %b required 0", l3_d_rvalid);
        end
        $display("load lat3: addr=%h rdata=%h", 32'h1001_0004, l3_d_rdata);
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        logic gi, gd;
        int   cyc;
        logic seen;
        l3_if_addr = 32'h0040_0040;
        l3_if_req  = 1;
        wait_gnt(1'b1, gi, gd, cyc);
        l3_if_req = 0;
        tick();
        #2;
        rst = 0;
        #1;
        checks++;
        if (l3_outs !== '0) begin
            errors++;
            $display("FAIL reset_mid_outs: got %h required 0", l3_outs);
        end
        @(posedge clk);
        #1;
        rst  = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | l3_if_rvalid | l3_busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_discard: if_rvalid/busy seen=%b required 0", seen);
        end
        l3_d_addr = 32'h1001_0004;
        l3_d_we   = 0;
        l3_d_req  = 1;
        wait_gnt(1'b1, gi, gd, cyc);
        checks++;
        if ({gd, cyc == 1} !== 2'b11) begin
            errors++;
            $display("FAIL reset_mid_gnt: d_gnt got %b after %0d cycles required 1 after 1", gd, cyc);
        end
        l3_d_req = 0;
        repeat (4) tick();
        checks++;
        if ({l3_d_rvalid, l3_d_rdata, l3_if_rvalid} !== {1'b1, 32'h1234_5678, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_load: d_rvalid/d_rdata/if_rvalid got %b %h %b required 1 12345678 0",
                     l3_d_rvalid, l3_d_rdata, l3_if_rvalid);
        end
        $display("reset mid-wait: in-flight fetch dropped, load rdata=%h", l3_d_rdata);
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        logic gi, gd;
        int   cyc;
        do_reset();
        l1_d_addr = 32'h1001_0030;
        l1_d_we   = 0;
        l1_d_req  = 1;
        wait_gnt(1'b0, gi, gd, cyc);
        checks++;
        if ({gd, gi, cyc == 1} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_first: d/if gnt got %b%b after %0d required 10 after 1", gd, gi, cyc);
        end
        wait_gnt(1'b0, gi, gd, cyc);
        checks++;
        if ({gd, gi, cyc == 4} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_second: d/if gnt got %b%b after %0d required 10 after 4", gd, gi, cyc);
        end
        l1_if_addr = 32'h0040_0020;
        l1_if_req  = 1;
        wait_gnt(1'b0, gi, gd, cyc);
        checks++;
        if ({gi, gd, l1_mem_addr, cyc == 4} !== {2'b10, 32'h0040_0020, 1'b1}) begin
            errors++;
            $display("FAIL b2b_if_turn: if/d gnt got %b%b addr %h after %0d required 10 00400020 after 4",
                     gi, gd, l1_mem_addr, cyc);
        end
        l1_if_req = 0;
        wait_gnt(1'b0, gi, gd, cyc);
        checks++;
        if ({gd, gi, l1_mem_addr, cyc == 4} !== {2'b10, 32'h1001_0030, 1'b1}) begin
            errors++;
            $display("FAIL b2b_d_resume: d/if gnt got %b%b addr %h after %0d required 10 10010030 after 4",
                     gd, gi, l1_mem_addr, cyc);
        end
        l1_d_req = 0;
        $display("back-to-back: D, D, IF, D granted");
        repeat (5) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_round_robin();
        test_store();
        test_load_lat3();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
